dma_wr_packer: RTL and testbench

- Write-domain front end of the DDR3 DMA write path.
- Packs narrow stream beats into wide words and pushes them into the show-ahead async FIFO's write port (w_en/w_din/w_full).
- Frames FIFO content into DDR bursts and raises a burst request for the memory-side engine.
- Lives entirely in the w_clk_i domain.

---
 rtl/dma_wr_pkg.sv | 16 +
 rtl/dma_wr_lane_acc.sv | 60 ++++++
 rtl/dma_wr_packer.sv | 91 +++++++++
 tb/tb_dma_wr_packer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_wr_pkg.sv
// dma_wr_pkg: shared state type and width helpers for the DMA write packer.
// DMA_WR_LANE_MASK_EN widens the FIFO word by one written-lane bit per lane.
package dma_wr_pkg;
    typedef enum logic {FILL, REQ} state_t;
`ifdef DMA_WR_LANE_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif
    function automatic int fifo_dw(input int in_w, input int ratio);
        return in_w * ratio + (MASK_EN ? ratio : 0);
    endfunction
    function automatic int lane_w(input int ratio);
        return $clog2(ratio);
    endfunction
endpackage

// File: rtl/dma_wr_lane_acc.sv
// dma_wr_lane_acc: gathers narrow beats into one FIFO word and flags word completion.
// DMA_WR_LANE_MASK_EN prepends a mask of the lanes written into the word.
module dma_wr_lane_acc
    import dma_wr_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int RATIO = 4
) (
    input  logic                            asyn_reset_i,
    input  logic                            w_clk_i,
    input  logic                            i_fire,
    input  logic [IN_W-1:0]                 i_data,
    input  logic                            i_last,
    output logic                            o_done,
    output logic                            o_last,
    output logic [fifo_dw(IN_W, RATIO)-1:0] o_word,
    output logic [lane_w(RATIO)-1:0]        o_lane_cnt
);
    localparam int LW = lane_w(RATIO);
    localparam int DW = IN_W * RATIO;

    logic [LW-1:0] r_lane;
    logic [DW-1:0] r_acc, w_data;

    assign o_done     = i_fire & (i_last | (r_lane == LW'(RATIO - 1)));
    assign o_last     = i_last;
    assign o_lane_cnt = r_lane;

    // Lanes above the current one are still zero, so a short last word is zero-filled for free.
    always_comb begin
        w_data = r_acc;
        w_data[r_lane*IN_W +: IN_W] = i_data;
    end

    always_ff @(posedge w_clk_i or posedge asyn_reset_i) begin
        if (asyn_reset_i) begin
            r_lane <= '0;
            r_acc  <= '0;
        end else if (i_fire) begin
            r_lane <= o_done ? '0 : r_lane + 1'b1;
            r_acc  <= o_done ? '0 : w_data;
        end
    end

`ifdef DMA_WR_LANE_MASK_EN
    logic [RATIO-1:0] r_mask, w_mask;

    assign w_mask = r_mask | (RATIO'(1) << r_lane);
    assign o_word = {w_mask, w_data};

    always_ff @(posedge w_clk_i or posedge asyn_reset_i) begin
        if (asyn_reset_i)
            r_mask <= '0;
        else if (i_fire)
            r_mask <= o_done ? '0 : w_mask;
    end
`else
    assign o_word = w_data;
`endif
endmodule

// File: rtl/dma_wr_packer.sv
// dma_wr_packer: packs stream beats into FIFO words and frames them into DDR burst requests.
// DMA_WR_LANE_MASK_EN adds a per-lane written mask above the data in fifo_w_din_o.
module dma_wr_packer
    import dma_wr_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int RATIO     = 4,
    parameter int BURST_LEN = 8,
    parameter int LEN_W     = 4
) (
    input  logic                            asyn_reset_i,
    input  logic                            w_clk_i,
    input  logic                            in_valid_i,
    input  logic [IN_W-1:0]                 in_data_i,
    input  logic                            in_last_i,
    output logic                            in_ready_o,
    output logic                            fifo_w_en_o,
    output logic [fifo_dw(IN_W, RATIO)-1:0] fifo_w_din_o,
    input  logic                            fifo_full_i,
    output logic                            burst_req_o,
    output logic [LEN_W-1:0]                burst_len_o,
    input  logic                            burst_ack_i,
    output logic                            busy_o
);
    localparam int FDW = fifo_dw(IN_W, RATIO);

    logic                     w_fire, w_done, w_last, w_close;
    logic [FDW-1:0]           w_word, r_out_q;
    logic [lane_w(RATIO)-1:0] w_lane_cnt;
    logic                     r_out_valid, r_out_last, r_burst_req;
    logic [LEN_W-1:0]         r_word_cnt, r_burst_len;
    state_t                   r_state;

    // A held word blocks input unless it retires this cycle, so a completing beat always lands.
    assign fifo_w_en_o  = r_out_valid & ~fifo_full_i & (r_state == FILL);
    assign in_ready_o   = ~(r_out_valid & ~fifo_w_en_o);
    assign w_fire       = in_valid_i & in_ready_o;
    assign w_close      = fifo_w_en_o & (r_out_last | (r_word_cnt == LEN_W'(BURST_LEN - 1)));
    assign fifo_w_din_o = r_out_q;
    assign burst_req_o  = r_burst_req;
    assign burst_len_o  = r_burst_len;
    assign busy_o       = (w_lane_cnt != '0) | r_out_valid | (r_word_cnt != '0) | (r_state == REQ);

    dma_wr_lane_acc #(
        .IN_W (IN_W),
        .RATIO(RATIO)
    ) u_lane_acc (
        .asyn_reset_i(asyn_reset_i),
        .w_clk_i     (w_clk_i),
        .i_fire      (w_fire),
        .i_data      (in_data_i),
        .i_last      (in_last_i),
        .o_done      (w_done),
        .o_last      (w_last),
        .o_word      (w_word),
        .o_lane_cnt  (w_lane_cnt)
    );

    always_ff @(posedge w_clk_i or posedge asyn_reset_i) begin
        if (asyn_reset_i) begin
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_done) begin
            r_out_q     <= w_word;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last;
        end else if (fifo_w_en_o) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge w_clk_i or posedge asyn_reset_i) begin
        if (asyn_reset_i) begin
            r_state     <= FILL;
            r_word_cnt  <= '0;
            r_burst_len <= '0;
            r_burst_req <= 1'b0;
        end else if (w_close) begin
            r_state     <= REQ;
            r_burst_len <= r_word_cnt + 1'b1;
            r_word_cnt  <= '0;
            r_burst_req <= 1'b1;
        end else if (fifo_w_en_o) begin
            r_word_cnt  <= r_word_cnt + 1'b1;
        end else if (r_state == REQ && burst_ack_i) begin
            r_state     <= FILL;
            r_burst_req <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dma_wr_packer.sv
// tb_dma_wr_packer: scoreboard bench for dma_wr_packer with default parameters.
// Define DMA_WR_LANE_MASK_EN at build time to exercise the lane-mask variant.
module tb_dma_wr_packer;
    import dma_wr_pkg::*;
    localparam int FDW = fifo_dw(32, 4);

    logic            asyn_reset_i, in_valid_i, in_last_i, fifo_full_i, burst_ack_i;
    logic            w_clk_i = 1'b0;
    logic [31:0]     in_data_i;
    logic            in_ready_o, fifo_w_en_o, burst_req_o, busy_o;
    logic [FDW-1:0]  fifo_w_din_o;
    logic [3:0]      burst_len_o;

    int vectors = 0, errors = 0, stalls = 0, writes = 0, bursts = 0;
    logic auto_ack = 1'b1;
    logic prev_req = 1'b0, prev_wen = 1'b0;
    logic [FDW-1:0] last_din = '0;
    logic [FDW-1:0] exp_words[$];
    logic [3:0]     exp_lens[$];
    logic [127:0]   m_data = '0;
    logic [3:0]     m_mask = '0;
    int             m_lane = 0, m_words = 0;

    dma_wr_packer dut (
        .asyn_reset_i(asyn_reset_i),
        .w_clk_i     (w_clk_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .fifo_w_en_o (fifo_w_en_o),
        .fifo_w_din_o(fifo_w_din_o),
        .fifo_full_i (fifo_full_i),
        .burst_req_o (burst_req_o),
        .burst_len_o (burst_len_o),
        .burst_ack_i (burst_ack_i),
        .busy_o      (busy_o)
    );

    always #5 w_clk_i = ~w_clk_i;

    function automatic logic [FDW-1:0] mk_word(input logic [127:0] d, input logic [3:0] m);
        logic [FDW-1:0] w;
        w = FDW'(d);
`ifdef DMA_WR_LANE_MASK_EN
        w[FDW-1 -: 4] = m;
`endif
        return w;
    endfunction

    task automatic tick();
        @(posedge w_clk_i);
        #1;
    endtask

    // Reference packing: builds expected FIFO words and burst lengths from accepted beats.
    task automatic model_accept(input logic [31:0] d, input logic l);
        m_data[m_lane*32 +: 32] = d;
        m_mask[m_lane] = 1'b1;
        if (m_lane == 3 || l) begin
            exp_words.push_back(mk_word(m_data, m_mask));
            m_words++;
            if (m_words == 8 || l) begin
                exp_lens.push_back(4'(m_words));
                m_words = 0;
            end
            m_data = '0;
            m_mask = '0;
            m_lane = 0;
        end else begin
            m_lane++;
        end
    endtask

    task automatic model_flush();
        exp_words.delete();
        exp_lens.delete();
        m_data = '0;
        m_mask = '0;
        m_lane = 0;
        m_words = 0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n = 0;
        in_valid_i = 1'b1;
        in_data_i = d;
        in_last_i = l;
        #3;
        while (!in_ready_o && n < 200) begin
            stalls++;
            @(posedge w_clk_i);
            #4;
            n++;
        end
        if (n >= 200) begin
            vectors++;
            errors++;
            $display("FAIL beat_accept: in_ready_o=%b after %0d cycles, required 1", in_ready_o, n);
        end else begin
            model_accept(d, l);
        end
        @(posedge w_clk_i);
        #1;
        in_valid_i = 1'b0;
        in_last_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_words.size() != 0 || exp_lens.size() != 0 || burst_req_o) && n < 1000) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL drain: %0d words and %0d bursts outstanding, required 0 and 0", exp_words.size(), exp_lens.size());
        end
        tick();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!burst_req_o && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (burst_req_o !== 1'b1) begin
            errors++;
            $display("FAIL wait_req: burst_req_o=%b, required 1", burst_req_o);
        end
    endtask

    task automatic do_reset();
        asyn_reset_i = 1'b1;
        model_flush();
        tick();
        tick();
        asyn_reset_i = 1'b0;
        tick();
    endtask

    initial begin
        burst_ack_i = 1'b0;
        forever begin
            tick();
            if (auto_ack && burst_req_o) begin
                tick();
                tick();
                burst_ack_i = 1'b1;
                tick();
                burst_ack_i = 1'b0;
            end
        end
    end

    always @(negedge w_clk_i) begin
        if (fifo_w_en_o) begin
            vectors++;
            if (fifo_full_i !== 1'b0 || burst_req_o !== 1'b0) begin
                errors++;
                $display("FAIL wen_legal: fifo_w_en_o=1 with full=%b req=%b, required full=0 req=0", fifo_full_i, burst_req_o);
            end
            vectors++;
            if (exp_words.size() == 0) begin
                errors++;
                $display("FAIL word: unexpected write %h, required no write", fifo_w_din_o);
            end else begin
                logic [FDW-1:0] e;
                e = exp_words.pop_front();
                if (fifo_w_din_o !== e) begin
                    errors++;
                    $display("FAIL word: got %h, required %h", fifo_w_din_o, e);
                end
            end
            last_din = fifo_w_din_o;
            writes++;
        end
        if (burst_req_o && !prev_req) begin
            bursts++;
            vectors++;
            if (prev_wen !== 1'b1) begin
                errors++;
                $display("FAIL req_timing: write in cycle before request=%b, required 1", prev_wen);
            end
            vectors++;
            if (exp_lens.size() == 0) begin
                errors++;
                $display("FAIL burst_len: unexpected request len=%0d, required none", burst_len_o);
            end else begin
                logic [3:0] e;
                e = exp_lens.pop_front();
                if (burst_len_o !== e) begin
                    errors++;
                    $display("FAIL burst_len: got %0d, required %0d", burst_len_o, e);
                end
            end
        end
        prev_req = burst_req_o;
        prev_wen = fifo_w_en_o;
    end

    task automatic test_reset();
        #2;
        vectors += 6;
        if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", in_ready_o); end
        if (fifo_w_en_o !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b, required 0", fifo_w_en_o); end
        if (fifo_w_din_o !== '0) begin errors++; $display("FAIL rst_din: got %h, required 0", fifo_w_din_o); end
        if (burst_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b, required 0", burst_req_o); end
        if (burst_len_o !== 4'd0) begin errors++; $display("FAIL rst_len: got %0d, required 0", burst_len_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
        tick();
        asyn_reset_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int w0;
        do_reset();
        stalls = 0;
        w0 = writes;
        for (int k = 1; k <= 8; k++) send_beat(32'(k) * 32'h11111111, 1'b0);
        wait_idle();
        vectors += 3;
        if (stalls != 0) begin errors++; $display("FAIL basic_ready: %0d stall cycles, required 0", stalls); end
        if (writes - w0 != 2) begin errors++; $display("FAIL basic_count: %0d writes, required 2", writes - w0); end
        if (last_din !== mk_word(128'h88888888777777776666666655555555, 4'hf)) begin
            errors++;
            $display("FAIL basic_word: got %h, required 88888888777777776666666655555555", last_din);
        end
    endtask

    task automatic test_back_to_back();
        int w0, b0;
        do_reset();
        auto_ack = 1'b1;
        w0 = writes;
        b0 = bursts;
        for (int k = 0; k < 64; k++) send_beat($urandom, 1'b0);
        wait_idle();
        vectors += 2;
        if (writes - w0 != 16) begin errors++; $display("FAIL b2b_count: %0d writes, required 16", writes - w0); end
        if (bursts - b0 != 2) begin errors++; $display("FAIL b2b_bursts: %0d bursts, required 2", bursts - b0); end
    endtask

    task automatic test_last();
        do_reset();
        for (int k = 1; k <= 6; k++) send_beat(32'(k) * 32'h11111111, k == 6);
        wait_req();
        vectors++;
        if (burst_len_o !== 4'd2) begin errors++; $display("FAIL last_len: got %0d, required 2", burst_len_o); end
        wait_idle();
        vectors += 2;
        if (last_din !== mk_word(128'h00000000000000006666666655555555, 4'b0011)) begin
            errors++;
            $display("FAIL last_word: got %h, required zero-filled lanes 2,3", last_din);
        end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL last_busy: got %b, required 0", busy_o); end
    endtask

    task automatic test_full_stall();
        int w0;
        logic saw_stall;
        do_reset();
        w0 = writes;
        saw_stall = 1'b0;
        fork
            for (int k = 0; k < 12; k++) send_beat(32'hA0000000 + 32'(k), 1'b0);
            begin
                tick();
                tick();
                fifo_full_i = 1'b1;
                repeat (10) begin
                    @(posedge w_clk_i);
                    #3;
                    vectors++;
                    if (fifo_w_en_o !== 1'b0) begin errors++; $display("FAIL full_wen: got %b, required 0", fifo_w_en_o); end
                    if (!in_ready_o) saw_stall = 1'b1;
                end
                tick();
                fifo_full_i = 1'b0;
            end
        join
        wait_idle();
        vectors += 2;
        if (saw_stall !== 1'b1) begin errors++; $display("FAIL full_ready: in_ready_o low seen=%b, required 1", saw_stall); end
        if (writes - w0 != 3) begin errors++; $display("FAIL full_count: %0d writes, required 3", writes - w0); end
    endtask

    task automatic test_reset_in_req();
        do_reset();
        auto_ack = 1'b0;
        send_beat(32'hC0DE0001, 1'b1);
        wait_req();
        send_beat(32'hC0DE0002, 1'b0);
        send_beat(32'hC0DE0003, 1'b0);
        vectors += 2;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL req_busy: got %b, required 1", busy_o); end
        if (burst_req_o !== 1'b1) begin errors++; $display("FAIL req_hold: got %b, required 1", burst_req_o); end
        asyn_reset_i = 1'b1;
        #1;
        vectors += 4;
        if (burst_req_o !== 1'b0) begin errors++; $display("FAIL arst_req: got %b, required 0", burst_req_o); end
        if (fifo_w_en_o !== 1'b0) begin errors++; $display("FAIL arst_wen: got %b, required 0", fifo_w_en_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b, required 0", busy_o); end
        if (in_ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b, required 1", in_ready_o); end
        model_flush();
        tick();
        tick();
        asyn_reset_i = 1'b0;
        auto_ack = 1'b1;
        tick();
        send_beat(32'hD0000000, 1'b0);
        send_beat(32'hE0000000, 1'b0);
        send_beat(32'hF0000000, 1'b0);
        send_beat(32'h90000000, 1'b1);
        wait_req();
        vectors++;
        if (burst_len_o !== 4'd1) begin errors++; $display("FAIL post_len: got %0d, required 1", burst_len_o); end
        wait_idle();
        vectors++;
        if (last_din !== mk_word(128'h90000000F0000000E0000000D0000000, 4'hf)) begin
            errors++;
            $display("FAIL post_word: got %h, required 90000000f0000000e0000000d0000000", last_din);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        asyn_reset_i = 1'b1;
        in_valid_i = 1'b0;
        in_data_i = '0;
        in_last_i = 1'b0;
        fifo_full_i = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_last();
        test_full_stall();
        test_reset_in_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
